fft_addr_gen: RTL and testbench

FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

---
 rtl/fft_pkg.sv | 14 +
 rtl/addr_delay_line.sv | 25 ++
 rtl/fft_addr_gen.sv | 137 +++++++++++++
 tb/tb_fft_addr_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FSM encoding and default transform sizing for the FFT address generator.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_e;

    localparam int unsigned FFT_N_LOG2     = 5;
    localparam int unsigned FFT_RW_LATENCY = 3;

endpackage

// File: rtl/addr_delay_line.sv
// Fixed-depth register pipeline with asynchronous active-low clear.
module addr_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= i_data;
            for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
        end
    end

    assign o_data = pipe[DEPTH-1];

endmodule

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT in-place FFT address sequencer: butterfly read addresses,
// twiddle index and write-back addresses delayed by the datapath latency.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int unsigned N_LOG2         = FFT_N_LOG2,
    parameter int unsigned ADDR_SIZE      = N_LOG2,
    parameter int unsigned TWID_ADDR_SIZE = N_LOG2 - 1,
    parameter int unsigned RW_LATENCY     = FFT_RW_LATENCY
) (
    input  logic                       i_CLK,
    input  logic                       i_RST_N,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_rden,
    output logic [ADDR_SIZE-1:0]       o_rdaddr_A,
    output logic [ADDR_SIZE-1:0]       o_rdaddr_B,
    output logic [TWID_ADDR_SIZE-1:0]  o_rdaddr_tw,
    output logic                       o_wren,
    output logic [ADDR_SIZE-1:0]       o_wraddr_A,
    output logic [ADDR_SIZE-1:0]       o_wraddr_B,
    output logic [$clog2(N_LOG2)-1:0]  o_stage
);

    localparam int unsigned SW  = $clog2(N_LOG2);
    localparam int unsigned KW  = N_LOG2 - 1;
    localparam int unsigned DW  = $clog2(RW_LATENCY + 1);
    localparam int unsigned DLW = 2 * ADDR_SIZE + 1;

    localparam logic [KW-1:0] K_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);
    localparam logic [DW-1:0] D_LAST = DW'(RW_LATENCY - 1);

    fft_state_e       state_q, state_d;
    logic [SW-1:0]    s_q;
    logic [KW-1:0]    k_q;
    logic [DW-1:0]    dcnt_q;

    logic [N_LOG2-1:0] k_ext, half, pos, a_c, b_c, tw_c;
    logic [SW-1:0]     tw_sh;
    logic [DLW-1:0]    wr_bus;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_start) state_d = ST_READ;
            ST_READ:  if (k_q == K_LAST) state_d = ST_DRAIN;
            ST_DRAIN: if (dcnt_q == D_LAST) state_d = (s_q == S_LAST) ? ST_DONE : ST_READ;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Stage, butterfly and drain counters; all parked at zero outside a transform.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            s_q    <= '0;
            k_q    <= '0;
            dcnt_q <= '0;
        end else begin
            case (state_q)
                ST_READ: begin
                    k_q <= (k_q == K_LAST) ? '0 : k_q + KW'(1);
                end
                ST_DRAIN: begin
                    if (dcnt_q == D_LAST) begin
                        dcnt_q <= '0;
                        if (s_q != S_LAST) s_q <= s_q + SW'(1);
                    end else begin
                        dcnt_q <= dcnt_q + DW'(1);
                    end
                end
                ST_DONE: begin
                    s_q    <= '0;
                    k_q    <= '0;
                    dcnt_q <= '0;
                end
                default: begin
                    k_q    <= '0;
                    dcnt_q <= '0;
                end
            endcase
        end
    end

    // A is k with a zero inserted at bit s; B sets that bit; twiddle scales pos to N/2 span.
    always_comb begin
        k_ext = N_LOG2'(k_q);
        half  = N_LOG2'(1) << s_q;
        pos   = k_ext & (half - N_LOG2'(1));
        a_c   = (((k_ext >> s_q) << s_q) << 1) | pos;
        b_c   = a_c | half;
        tw_sh = S_LAST - s_q;
        tw_c  = pos << tw_sh;
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_rden      <= 1'b0;
            o_stage     <= '0;
            o_rdaddr_A  <= '0;
            o_rdaddr_B  <= '0;
            o_rdaddr_tw <= '0;
        end else begin
            o_busy  <= (state_q == ST_READ) || (state_q == ST_DRAIN);
            o_done  <= (state_q == ST_DONE);
            o_rden  <= (state_q == ST_READ);
            o_stage <= s_q;
            if (state_q == ST_READ) begin
                o_rdaddr_A  <= ADDR_SIZE'(a_c);
                o_rdaddr_B  <= ADDR_SIZE'(b_c);
                o_rdaddr_tw <= TWID_ADDR_SIZE'(tw_c);
            end
        end
    end

    addr_delay_line #(
        .DEPTH (RW_LATENCY),
        .WIDTH (DLW)
    ) u_wr_dly (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .i_data  ({o_rden, o_rdaddr_A, o_rdaddr_B}),
        .o_data  (wr_bus)
    );

    assign {o_wren, o_wraddr_A, o_wraddr_B} = wr_bus;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Bench for fft_addr_gen: per-cycle comparison against an arithmetic model of the
// transform schedule, plus directed literal expectations for two configurations.
module tb_fft_addr_gen;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    logic       busy0, done0, rden0, wren0;
    logic [4:0] ra0, rb0, wa0, wb0;
    logic [3:0] rtw0;
    logic [2:0] stg0;

    logic       busy1, done1, rden1, wren1;
    logic [2:0] ra1, rb1, wa1, wb1;
    logic [1:0] rtw1;
    logic [1:0] stg1;

    fft_addr_gen u_dut0 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_start(start0),
        .o_busy(busy0), .o_done(done0), .o_rden(rden0),
        .o_rdaddr_A(ra0), .o_rdaddr_B(rb0), .o_rdaddr_tw(rtw0),
        .o_wren(wren0), .o_wraddr_A(wa0), .o_wraddr_B(wb0), .o_stage(stg0)
    );

    fft_addr_gen #(.N_LOG2(3), .RW_LATENCY(1)) u_dut1 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_start(start1),
        .o_busy(busy1), .o_done(done1), .o_rden(rden1),
        .o_rdaddr_A(ra1), .o_rdaddr_B(rb1), .o_rdaddr_tw(rtw1),
        .o_wren(wren1), .o_wraddr_A(wa1), .o_wraddr_B(wb1), .o_stage(stg1)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int m_start  [2];
    bit m_act    [2];
    bit h_rd     [2][8];
    int h_a      [2][8];
    int h_b      [2][8];
    int last_a   [2];
    int last_b   [2];
    int last_tw  [2];
    int wren_cnt [2];
    int done_cnt [2];
    int done_cyc [2];

    bit s_st0, s_st1, s_rs;

    logic [7:0] mask [3];
    int dup, reads, t, t1;

    function automatic void chk(string nm, int id, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d got=%0d exp=%0d", nm, id, cyc, got, exp);
    endfunction

    // Schedule model: stage s occupies N/2 read cycles then RW idle cycles, done one cycle after.
    task automatic model_check(input int id, input int nl, input int rw, input bit st, input bit rs,
                               input logic [31:0] rden, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] tw, input logic [31:0] wren, input logic [31:0] wa,
                               input logic [31:0] wb, input logic [31:0] busy, input logic [31:0] done,
                               input logic [31:0] stg);
        int nh, len, per, j, idx, s, r, half, pos, grp, e_stg, hi;
        bit e_rd, e_busy, e_done;
        nh = 1 << (nl - 1);
        len = nh + rw;
        per = nl * len + 2;
        e_rd = 0; e_busy = 0; e_done = 0; e_stg = 0;
        if (!rs) begin
            m_act[id] = 0;
            last_a[id] = 0; last_b[id] = 0; last_tw[id] = 0;
            for (int i = 0; i < 8; i++) begin
                h_rd[id][i] = 0; h_a[id][i] = 0; h_b[id][i] = 0;
            end
        end else if (st && (!m_act[id] || cyc >= m_start[id] + per)) begin
            m_act[id] = 1;
            m_start[id] = cyc;
        end
        if (rs && m_act[id]) begin
            j = cyc - m_start[id];
            idx = j - 1;
            if (j >= 1 && idx < nl * len) begin
                s = idx / len;
                r = idx % len;
                e_busy = 1;
                e_stg = s;
                if (r < nh) begin
                    half = 1 << s;
                    pos = r % half;
                    grp = r / half;
                    e_rd = 1;
                    last_a[id] = grp * 2 * half + pos;
                    last_b[id] = last_a[id] + half;
                    last_tw[id] = pos * (1 << (nl - 1 - s));
                end
            end
            e_done = (j == nl * len + 1);
        end
        if (rs) begin
            h_rd[id][cyc % 8] = e_rd;
            h_a[id][cyc % 8]  = last_a[id];
            h_b[id][cyc % 8]  = last_b[id];
        end
        hi = (cyc + 8 - rw) % 8;
        chk("rden", id, rden, 32'(e_rd));
        chk("rdaddr_A", id, a, 32'(last_a[id]));
        chk("rdaddr_B", id, b, 32'(last_b[id]));
        chk("rdaddr_tw", id, tw, 32'(last_tw[id]));
        chk("wren", id, wren, 32'(h_rd[id][hi]));
        chk("wraddr_A", id, wa, 32'(h_a[id][hi]));
        chk("wraddr_B", id, wb, 32'(h_b[id][hi]));
        chk("busy", id, busy, 32'(e_busy));
        chk("done", id, done, 32'(e_done));
        if (e_busy) chk("stage", id, stg, 32'(e_stg));
        if (wren === 32'd1) wren_cnt[id]++;
        if (done === 32'd1) begin
            done_cnt[id]++;
            done_cyc[id] = cyc;
        end
    endtask

    always @(posedge clk) begin
        s_st0 = start0;
        s_st1 = start1;
        s_rs  = rst_n;
        cyc   = cyc + 1;
        #1;
        model_check(0, 5, 3, s_st0, s_rs, 32'(rden0), 32'(ra0), 32'(rb0), 32'(rtw0),
                    32'(wren0), 32'(wa0), 32'(wb0), 32'(busy0), 32'(done0), 32'(stg0));
        model_check(1, 3, 1, s_st1, s_rs, 32'(rden1), 32'(ra1), 32'(rb1), 32'(rtw1),
                    32'(wren1), 32'(wa1), 32'(wb1), 32'(busy1), 32'(done1), 32'(stg1));
    end

    task automatic wait_to(input int target);
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            #2;
            guard++;
        end while (cyc < target && guard < 1000);
        if (cyc != target) begin
            n_chk++;
            $display("FAIL wait_to cyc=%0d got=%0d exp=%0d", cyc, cyc, target);
        end
    endtask

    task automatic pulse0(output int ts);
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        ts = m_start[0];
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, "_rden"}, 0, 32'(rden0), 0);
        chk({tag, "_rdA"},  0, 32'(ra0), 0);
        chk({tag, "_rdB"},  0, 32'(rb0), 0);
        chk({tag, "_tw"},   0, 32'(rtw0), 0);
        chk({tag, "_wren"}, 0, 32'(wren0), 0);
        chk({tag, "_wrA"},  0, 32'(wa0), 0);
        chk({tag, "_wrB"},  0, 32'(wb0), 0);
        chk({tag, "_busy"}, 0, 32'(busy0), 0);
        chk({tag, "_done"}, 0, 32'(done0), 0);
        chk({tag, "_stage"},0, 32'(stg0), 0);
    endtask

    task automatic chk_rd0(input string tag, input int a, input int b, input int tw, input int s);
        chk({tag, "_rden"}, 0, 32'(rden0), 1);
        chk({tag, "_A"},    0, 32'(ra0), 32'(a));
        chk({tag, "_B"},    0, 32'(rb0), 32'(b));
        chk({tag, "_tw"},   0, 32'(rtw0), 32'(tw));
        chk({tag, "_stage"},0, 32'(stg0), 32'(s));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk_zero0("reset");
        chk("reset_rden1", 1, 32'(rden1), 0);
        chk("reset_busy1", 1, 32'(busy1), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single transform, default configuration
        wren_cnt[0] = 0; done_cnt[0] = 0;
        pulse0(t);
        wait_to(t + 1);  chk_rd0("s0k0", 0, 1, 0, 0);
        chk("s0k0_busy", 0, 32'(busy0), 1);
        wait_to(t + 4);
        chk("wr_s0k0_wren", 0, 32'(wren0), 1);
        chk("wr_s0k0_A", 0, 32'(wa0), 0);
        chk("wr_s0k0_B", 0, 32'(wb0), 1);
        wait_to(t + 21); chk_rd0("s1k1", 1, 3, 8, 1);
        wait_to(t + 22); chk_rd0("s1k2", 4, 6, 0, 1);
        wait_to(t + 92); chk_rd0("s4k15", 15, 31, 15, 4);
        wait_to(t + 95); chk("done_early", 0, 32'(done0), 0);
        wait_to(t + 96); chk("done_96", 0, 32'(done0), 1);
        chk("busy_in_done", 0, 32'(busy0), 0);
        wait_to(t + 97); chk("done_pulse_len", 0, 32'(done0), 0);
        chk("wren_total", 0, 32'(wren_cnt[0]), 80);
        chk("done_latency", 0, 32'(done_cyc[0] - t), 96);

        // Start held high: one transform, next only after returning to IDLE
        repeat (2) @(negedge clk);
        done_cnt[0] = 0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk);
        t1 = m_start[0];
        wait_to(t1 + 96); chk("held_done1", 0, 32'(done0), 1);
        wait_to(t1 + 97); chk("held_idle_gap", 0, 32'(busy0), 0);
        wait_to(t1 + 98); chk("held_restart_busy", 0, 32'(busy0), 1);
        chk("held_restart_A", 0, 32'(ra0), 0);
        @(negedge clk) start0 = 1'b0;
        wait_to(t1 + 193); chk("held_done2", 0, 32'(done0), 1);
        repeat (120) @(negedge clk);
        chk("held_done_count", 0, 32'(done_cnt[0]), 2);
        chk("held_final_busy", 0, 32'(busy0), 0);

        // Reset in the middle of stage 2
        pulse0(t);
        wait_to(t + 44); chk_rd0("s2k5", 9, 13, 4, 2);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk_zero0("rst_mid");
        wren_cnt[0] = 0; done_cnt[0] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        chk("post_rst_wren", 0, 32'(wren_cnt[0]), 0);
        chk("post_rst_done", 0, 32'(done_cnt[0]), 0);
        pulse0(t);
        wait_to(t + 1);  chk_rd0("re_s0k0", 0, 1, 0, 0);
        wait_to(t + 96); chk("re_done_96", 0, 32'(done0), 1);
        chk("re_wren_total", 0, 32'(wren_cnt[0]), 80);

        // Small configuration: N_LOG2=3, RW_LATENCY=1
        for (int i = 0; i < 3; i++) mask[i] = 8'h00;
        dup = 0; reads = 0;
        wren_cnt[1] = 0; done_cnt[1] = 0;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        t = m_start[1];
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #2;
            if (rden1 === 1'b1 && stg1 < 2'd3) begin
                reads++;
                if (mask[stg1][ra1]) dup++;
                mask[stg1][ra1] = 1'b1;
                if (mask[stg1][rb1]) dup++;
                mask[stg1][rb1] = 1'b1;
            end
        end
        chk("n3_done_16", 1, 32'(done1), 1);
        chk("n3_done_latency", 1, 32'(done_cyc[1] - t), 16);
        chk("n3_reads", 1, 32'(reads), 12);
        chk("n3_dup", 1, 32'(dup), 0);
        chk("n3_cover_s0", 1, 32'(mask[0]), 32'hFF);
        chk("n3_cover_s1", 1, 32'(mask[1]), 32'hFF);
        chk("n3_cover_s2", 1, 32'(mask[2]), 32'hFF);
        chk("n3_wren_total", 1, 32'(wren_cnt[1]), 12);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
